// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter
// Purpose  : Shares one writeback/wakeup bus among NSRC issue queues. Each
//            source feeds a DEPTH-entry skid FIFO; a round-robin arbiter pops
//            one FIFO head per cycle onto the registered wb_* bus.
// Ports    : clk, rst (async, active-high), flush (sync)
//            valid_in/Pd_in/RegWr_in/tag_rob_in/data_in : per-source entry
//            stall_out : per-source back-pressure (FIFO non-empty)
//            wb_valid/wb_Pd/wb_RegWr/wb_tag_rob/wb_data/wb_src : granted entry
//            overflow  : sticky, set when an entry hits a full FIFO
// Revision : 1.0  initial release
// ============================================================================
module wb_arbiter #(
   parameter int NSRC  = 3,
   parameter int DEPTH = 2
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic                                       flush,
   input  logic [NSRC-1:0]                            valid_in,
   input  logic [NSRC-1:0][5:0]                       Pd_in,
   input  logic [NSRC-1:0]                            RegWr_in,
   input  logic [NSRC-1:0][5:0]                       tag_rob_in,
   input  logic [NSRC-1:0][31:0]                      data_in,
   output logic [NSRC-1:0]                            stall_out,
   output logic                                       wb_valid,
   output logic [5:0]                                 wb_Pd,
   output logic                                       wb_RegWr,
   output logic [5:0]                                 wb_tag_rob,
   output logic [31:0]                                wb_data,
   output logic [((NSRC > 1) ? $clog2(NSRC) : 1)-1:0] wb_src,
   output logic                                       overflow
);

   localparam int c_SW = (NSRC > 1) ? $clog2(NSRC) : 1;
   localparam int c_PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int c_CW = $clog2(DEPTH + 1);
   localparam int c_EW = 6 + 1 + 6 + 32;

   // Entry layout: {Pd, RegWr, tag_rob, data}
   logic [c_EW-1:0] r_mem   [NSRC][DEPTH];
   logic [c_PW-1:0] r_head  [NSRC];
   logic [c_PW-1:0] r_tail  [NSRC];
   logic [c_CW-1:0] r_count [NSRC];
   logic [c_SW-1:0] r_rr_ptr;

   logic [NSRC-1:0] w_nonempty;
   logic [NSRC-1:0] w_push;
   logic [NSRC-1:0] w_pop;
   logic [NSRC-1:0] w_ovf;
   logic            w_gnt;
   logic [c_SW-1:0] w_gnt_idx;
   logic [c_SW-1:0] w_cand;
   logic [c_EW-1:0] w_head_entry;

   // ---------------------------------------------------------------------
   // Per-source skid FIFOs
   // ---------------------------------------------------------------------
   for (genvar i = 0; i < NSRC; i++) begin : g_src
      assign w_nonempty[i] = (r_count[i] != '0);
      assign stall_out[i]  = w_nonempty[i];
      assign w_pop[i]      = w_gnt && (w_gnt_idx == c_SW'(i)) && !flush;
      // A full FIFO still accepts when its head leaves on the same edge.
      assign w_push[i]     = valid_in[i] && !flush &&
                             ((r_count[i] != c_CW'(DEPTH)) || w_pop[i]);
      assign w_ovf[i]      = valid_in[i] && !flush &&
                             (r_count[i] == c_CW'(DEPTH)) && !w_pop[i];

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_head[i]  <= '0;
            r_tail[i]  <= '0;
            r_count[i] <= '0;
         end else if (flush) begin
            r_head[i]  <= '0;
            r_tail[i]  <= '0;
            r_count[i] <= '0;
         end else begin
            if (w_push[i])
               r_tail[i] <= (r_tail[i] == c_PW'(DEPTH - 1)) ? '0 : r_tail[i] + c_PW'(1);
            if (w_pop[i])
               r_head[i] <= (r_head[i] == c_PW'(DEPTH - 1)) ? '0 : r_head[i] + c_PW'(1);
            unique case ({w_push[i], w_pop[i]})
               2'b10:   r_count[i] <= r_count[i] + c_CW'(1);
               2'b01:   r_count[i] <= r_count[i] - c_CW'(1);
               default: ;
            endcase
         end
      end

      // Storage needs no reset: only slots counted as occupied are read.
      always_ff @(posedge clk) begin
         if (w_push[i])
            r_mem[i][r_tail[i]] <= {Pd_in[i], RegWr_in[i], tag_rob_in[i], data_in[i]};
      end
   end

   // ---------------------------------------------------------------------
   // Round-robin arbitration: first non-empty FIFO at or after r_rr_ptr
   // ---------------------------------------------------------------------
   always_comb begin
      w_gnt     = 1'b0;
      w_gnt_idx = '0;
      w_cand    = '0;
      for (int k = 0; k < NSRC; k++) begin
         w_cand = c_SW'((int'(r_rr_ptr) + k) % NSRC);
         if (!w_gnt && w_nonempty[w_cand]) begin
            w_gnt     = 1'b1;
            w_gnt_idx = w_cand;
         end
      end
   end

   assign w_head_entry = r_mem[w_gnt_idx][r_head[w_gnt_idx]];

   // ---------------------------------------------------------------------
   // Registered writeback bus, rotation pointer and sticky overflow
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_valid   <= 1'b0;
         wb_Pd      <= '0;
         wb_RegWr   <= 1'b0;
         wb_tag_rob <= '0;
         wb_data    <= '0;
         wb_src     <= '0;
         r_rr_ptr   <= '0;
      end else if (flush || !w_gnt) begin
         wb_valid   <= 1'b0;
         wb_Pd      <= '0;
         wb_RegWr   <= 1'b0;
         wb_tag_rob <= '0;
         wb_data    <= '0;
         wb_src     <= '0;
         if (flush)
            r_rr_ptr <= '0;
      end else begin
         wb_valid   <= 1'b1;
         wb_Pd      <= w_head_entry[44:39];
         wb_RegWr   <= w_head_entry[38];
         wb_tag_rob <= w_head_entry[37:32];
         wb_data    <= w_head_entry[31:0];
         wb_src     <= w_gnt_idx;
         r_rr_ptr   <= c_SW'((int'(w_gnt_idx) + 1) % NSRC);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         overflow <= 1'b0;
      else if (|w_ovf)
         overflow <= 1'b1;
   end

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_arbiter
// Purpose  : Self-checking bench for wb_arbiter (NSRC=3, DEPTH=2). Expected
//            entries go into per-source queues when driven; a monitor pops
//            and compares them whenever the bus shows a valid entry.
// Revision : 1.0  initial release
// ============================================================================
module tb_wb_arbiter;

   localparam int NSRC = 3;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  flush;
   logic [NSRC-1:0]       valid_in;
   logic [NSRC-1:0][5:0]  Pd_in;
   logic [NSRC-1:0]       RegWr_in;
   logic [NSRC-1:0][5:0]  tag_rob_in;
   logic [NSRC-1:0][31:0] data_in;
   logic [NSRC-1:0]       stall_out;
   logic                  wb_valid;
   logic [5:0]            wb_Pd;
   logic                  wb_RegWr;
   logic [5:0]            wb_tag_rob;
   logic [31:0]           wb_data;
   logic [1:0]            wb_src;
   logic                  overflow;

   int errors = 0;
   int checks = 0;

   logic [44:0] sbq0[$];
   logic [44:0] sbq1[$];
   logic [44:0] sbq2[$];
   logic [44:0] mon_got;
   logic [44:0] mon_exp;
   bit          mon_have;

   wb_arbiter #(.NSRC(NSRC), .DEPTH(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .valid_in   (valid_in),
      .Pd_in      (Pd_in),
      .RegWr_in   (RegWr_in),
      .tag_rob_in (tag_rob_in),
      .data_in    (data_in),
      .stall_out  (stall_out),
      .wb_valid   (wb_valid),
      .wb_Pd      (wb_Pd),
      .wb_RegWr   (wb_RegWr),
      .wb_tag_rob (wb_tag_rob),
      .wb_data    (wb_data),
      .wb_src     (wb_src),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog expired");
   end

   // Scoreboard monitor: every valid bus entry must match the oldest
   // expected entry of the source it claims to come from.
   always @(posedge clk) begin
      #1;
      if (wb_valid === 1'b1) begin
         mon_got  = {wb_Pd, wb_RegWr, wb_tag_rob, wb_data};
         mon_have = 1'b0;
         mon_exp  = '0;
         case (wb_src)
            2'd0: if (sbq0.size() != 0) begin mon_exp = sbq0.pop_front(); mon_have = 1'b1; end
            2'd1: if (sbq1.size() != 0) begin mon_exp = sbq1.pop_front(); mon_have = 1'b1; end
            2'd2: if (sbq2.size() != 0) begin mon_exp = sbq2.pop_front(); mon_have = 1'b1; end
            default: ;
         endcase
         checks++;
         if (!mon_have) begin
            errors++;
            $display("FAIL scoreboard_unexpected: got src=%0d entry=%h required no entry", wb_src, mon_got);
         end else if (mon_got !== mon_exp) begin
            errors++;
            $display("FAIL scoreboard_payload: src=%0d got %h required %h", wb_src, mon_got, mon_exp);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      valid_in   = '0;
      flush      = 1'b0;
      Pd_in      = '0;
      RegWr_in   = '0;
      tag_rob_in = '0;
      data_in    = '0;
   endtask

   task automatic set_src(input logic [1:0] i, input logic [5:0] pd, input logic rw,
                          input logic [5:0] tag, input logic [31:0] d, input bit expect_out);
      valid_in[i]   = 1'b1;
      Pd_in[i]      = pd;
      RegWr_in[i]   = rw;
      tag_rob_in[i] = tag;
      data_in[i]    = d;
      if (expect_out) begin
         case (i)
            2'd0: sbq0.push_back({pd, rw, tag, d});
            2'd1: sbq1.push_back({pd, rw, tag, d});
            default: sbq2.push_back({pd, rw, tag, d});
         endcase
      end
   endtask

   task automatic test_reset();
      checks++;
      if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %b required 0", wb_valid); end
      checks++;
      if ({wb_Pd, wb_RegWr, wb_tag_rob, wb_data, wb_src} !== 47'd0) begin
         errors++; $display("FAIL reset_payload: got %h required 0", {wb_Pd, wb_RegWr, wb_tag_rob, wb_data, wb_src});
      end
      checks++;
      if (stall_out !== 3'b000) begin errors++; $display("FAIL reset_stall: got %b required 000", stall_out); end
      checks++;
      if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b required 0", overflow); end
   endtask

   task automatic test_single();
      set_src(2'd1, 6'd5, 1'b1, 6'd9, 32'h1234, 1'b1);
      tick();
      idle_inputs();
      checks++;
      if (stall_out !== 3'b010) begin errors++; $display("FAIL single_stall_set: got %b required 010", stall_out); end
      tick();
      checks++;
      if (wb_valid !== 1'b1 || wb_src !== 2'd1) begin
         errors++; $display("FAIL single_grant: got valid=%b src=%0d required valid=1 src=1", wb_valid, wb_src);
      end
      checks++;
      if (wb_Pd !== 6'd5 || wb_data !== 32'h1234) begin
         errors++; $display("FAIL single_payload: got Pd=%0d data=%h required Pd=5 data=1234", wb_Pd, wb_data);
      end
      checks++;
      if (stall_out !== 3'b000) begin errors++; $display("FAIL single_stall_clear: got %b required 000", stall_out); end
      tick();
      checks++;
      if ({wb_valid, wb_Pd, wb_RegWr, wb_tag_rob, wb_data, wb_src} !== 48'd0) begin
         errors++; $display("FAIL idle_bus_zero: got %h required 0", {wb_valid, wb_Pd, wb_RegWr, wb_tag_rob, wb_data, wb_src});
      end
   endtask

   task automatic test_round_robin();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      set_src(2'd0, 6'd10, 1'b1, 6'd1, 32'hA0, 1'b1);
      set_src(2'd1, 6'd11, 1'b0, 6'd2, 32'hA1, 1'b1);
      set_src(2'd2, 6'd12, 1'b1, 6'd3, 32'hA2, 1'b1);
      tick();
      idle_inputs();
      checks++;
      if (stall_out !== 3'b111) begin errors++; $display("FAIL rr_stall_all: got %b required 111", stall_out); end
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if (wb_valid !== 1'b1 || wb_src !== 2'(k)) begin
            errors++; $display("FAIL rr_order: got valid=%b src=%0d required valid=1 src=%0d", wb_valid, wb_src, k);
         end
      end
      tick();
      checks++;
      if (wb_valid !== 1'b0) begin errors++; $display("FAIL rr_done: got %b required 0", wb_valid); end
   endtask

   task automatic test_fairness();
      int g2;
      g2 = -1;
      for (int c = 0; c < 6; c++) begin
         idle_inputs();
         if (stall_out[0] == 1'b0)
            set_src(2'd0, 6'(c), 1'b1, 6'(10 + c), 32'(256 + c), 1'b1);
         if (c == 0)
            set_src(2'd2, 6'd33, 1'b0, 6'd44, 32'hCAFE, 1'b1);
         tick();
         if (wb_valid === 1'b1 && wb_src === 2'd2 && g2 < 0)
            g2 = c;
      end
      idle_inputs();
      repeat (3) tick();
      checks++;
      if (!(g2 >= 1 && g2 <= 2)) begin errors++; $display("FAIL fair_src2_wait: got edge %0d required 1..2", g2); end
      checks++;
      if (stall_out !== 3'b000) begin errors++; $display("FAIL fair_drained: got %b required 000", stall_out); end
   endtask

   task automatic test_back_to_back();
      for (int c = 0; c < 4; c++) begin
         idle_inputs();
         set_src(2'd0, 6'(20 + c), 1'b1, 6'(c), 32'(4096 + c), 1'b1);
         tick();
         if (c > 0) begin
            checks++;
            if (wb_valid !== 1'b1 || wb_src !== 2'd0 || stall_out !== 3'b001) begin
               errors++; $display("FAIL b2b_stream: got valid=%b src=%0d stall=%b required 1 0 001", wb_valid, wb_src, stall_out);
            end
         end
      end
      idle_inputs();
      tick();
      tick();
      checks++;
      if (overflow !== 1'b0 || wb_valid !== 1'b0) begin
         errors++; $display("FAIL b2b_end: got ovf=%b valid=%b required 0 0", overflow, wb_valid);
      end
   endtask

   task automatic test_overflow();
      flush = 1'b1;
      tick();
      idle_inputs();
      set_src(2'd0, 6'd1, 1'b1, 6'd1, 32'h55, 1'b1);
      tick();
      idle_inputs();
      tick();   // grants source 0, rotation now favours source 1
      set_src(2'd0, 6'd2, 1'b1, 6'd2, 32'hA, 1'b1);
      set_src(2'd1, 6'd3, 1'b1, 6'd3, 32'hB, 1'b1);
      set_src(2'd2, 6'd4, 1'b1, 6'd4, 32'hC, 1'b1);
      tick();
      idle_inputs();
      set_src(2'd0, 6'd5, 1'b0, 6'd5, 32'hD, 1'b1);
      tick();
      checks++;
      if (wb_src !== 2'd1 || overflow !== 1'b0) begin
         errors++; $display("FAIL ovf_step1: got src=%0d ovf=%b required src=1 ovf=0", wb_src, overflow);
      end
      idle_inputs();
      set_src(2'd0, 6'd6, 1'b1, 6'd6, 32'hE, 1'b0);   // arrives at a full FIFO
      tick();
      idle_inputs();
      checks++;
      if (wb_src !== 2'd2 || overflow !== 1'b1) begin
         errors++; $display("FAIL ovf_set: got src=%0d ovf=%b required src=2 ovf=1", wb_src, overflow);
      end
      for (int k = 0; k < 2; k++) begin
         tick();
         checks++;
         if (wb_valid !== 1'b1 || wb_src !== 2'd0) begin
            errors++; $display("FAIL ovf_drain: got valid=%b src=%0d required 1 0", wb_valid, wb_src);
         end
      end
      tick();
      checks++;
      if (wb_valid !== 1'b0) begin errors++; $display("FAIL ovf_dropped: got valid=%b required 0", wb_valid); end
   endtask

   task automatic test_flush();
      set_src(2'd1, 6'd7, 1'b1, 6'd7, 32'h77, 1'b0);
      set_src(2'd2, 6'd8, 1'b1, 6'd8, 32'h88, 1'b0);
      tick();
      idle_inputs();
      checks++;
      if (stall_out !== 3'b110) begin errors++; $display("FAIL flush_pre: got %b required 110", stall_out); end
      flush = 1'b1;
      set_src(2'd0, 6'd9, 1'b1, 6'd9, 32'h99, 1'b0);
      tick();
      idle_inputs();
      checks++;
      if (wb_valid !== 1'b0 || stall_out !== 3'b000 || overflow !== 1'b1) begin
         errors++; $display("FAIL flush_clear: got valid=%b stall=%b ovf=%b required 0 000 1", wb_valid, stall_out, overflow);
      end
      repeat (2) begin
         tick();
         checks++;
         if (wb_valid !== 1'b0) begin errors++; $display("FAIL flush_stale: got valid=%b required 0", wb_valid); end
      end
   endtask

   task automatic test_async_reset();
      set_src(2'd0, 6'd12, 1'b1, 6'd13, 32'hBEEF, 1'b1);
      set_src(2'd1, 6'd14, 1'b0, 6'd15, 32'hF00D, 1'b0);
      tick();
      idle_inputs();
      tick();
      checks++;
      if (wb_valid !== 1'b1 || stall_out !== 3'b010) begin
         errors++; $display("FAIL ar_pre: got valid=%b stall=%b required 1 010", wb_valid, stall_out);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (wb_valid !== 1'b0 || stall_out !== 3'b000 || overflow !== 1'b0 || wb_data !== 32'd0) begin
         errors++; $display("FAIL ar_immediate: got valid=%b stall=%b ovf=%b data=%h required 0 000 0 0",
                            wb_valid, stall_out, overflow, wb_data);
      end
      #1;
      rst = 1'b0;
      tick();
      set_src(2'd2, 6'd40, 1'b1, 6'd41, 32'h42, 1'b1);
      tick();
      idle_inputs();
      checks++;
      if (stall_out !== 3'b100) begin errors++; $display("FAIL post_reset_push: got %b required 100", stall_out); end
      tick();
      checks++;
      if (wb_valid !== 1'b1 || wb_src !== 2'd2) begin
         errors++; $display("FAIL post_reset_grant: got valid=%b src=%0d required 1 2", wb_valid, wb_src);
      end
      tick();
   endtask

   task automatic test_final();
      checks++;
      if (sbq0.size() + sbq1.size() + sbq2.size() != 0) begin
         errors++; $display("FAIL scoreboard_leftover: got %0d entries required 0", sbq0.size() + sbq1.size() + sbq2.size());
      end
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      rst = 1'b0;
      tick();
      test_single();
      test_round_robin();
      test_fairness();
      test_back_to_back();
      test_overflow();
      test_flush();
      test_async_reset();
      test_final();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter NSRC, default 3, number of requesting issue queues.
REQ-002 Parameter DEPTH, default 2, entries per source skid FIFO.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 flush  input  1  synchronous pipeline flush (mispredict/exception).
REQ-006 valid_in  input  NSRC x 1  source i presents an awake/writeback entry this cycle.
REQ-007 Pd_in  input  NSRC x 6  physical destination register per source.
REQ-008 RegWr_in  input  NSRC x 1  register-write enable per source.
REQ-009 tag_rob_in  input  NSRC x 6  ROB tag per source.
REQ-010 data_in  input  NSRC x 32  result/immediate payload per source.
REQ-011 stall_out  output  NSRC x 1  back-pressure to source i; combinational from FIFO count registers only.
REQ-012 wb_valid  output  1  registered; shared writeback/wakeup bus carries a valid entry.
REQ-013 wb_Pd, wb_RegWr, wb_tag_rob, wb_data  output  6/1/6/32  registered payload of granted entry.
REQ-014 wb_src  output  2  registered index of granted source.
REQ-015 overflow  output  1  sticky error flag; entry arrived at a full FIFO.

Function
REQ-016 Each source i SHALL own a DEPTH-entry FIFO with head/tail pointers and count register (0..DEPTH).
REQ-017 Push: valid_in[i] high at a rising edge SHALL write {Pd,RegWr,tag_rob,data} at tail if count<DEPTH, or if count==DEPTH and the same FIFO is popped that edge.
REQ-018 Push to a full FIFO not popped that edge SHALL drop the entry and set overflow; overflow clears only on rst.
REQ-019 stall_out[i] SHALL be high whenever count[i] >= 1 (one-entry headroom absorbs source's registered issue).
REQ-020 Arbitration: among FIFOs with count>=1, grant exactly one per cycle, round-robin starting from rr_ptr; rr_ptr SHALL update to (granted+1) mod NSRC; unchanged when nothing granted.
REQ-021 Grant SHALL pop the granted FIFO head and register its fields onto wb_* with wb_valid=1, wb_src=index, at the same edge.
REQ-022 No grant SHALL drive wb_valid=0 and all wb_* payload to 0 next cycle.
REQ-023 Latency: entry pushed at edge E, FIFO otherwise empty and winning arbitration, SHALL appear on wb_* after edge E+1 (2 cycles valid_in->wb_valid).
REQ-024 Simultaneous push and pop on one FIFO SHALL leave count unchanged and preserve FIFO order.
REQ-025 Pointers SHALL wrap modulo DEPTH; rr_ptr wraps modulo NSRC.
REQ-026 flush SHALL, at the next edge, empty all FIFOs (count=0, pointers=0), clear wb_* to 0, set rr_ptr=0, ignore same-cycle valid_in, and perform no grant; overflow unaffected.
REQ-027 flush has priority over push and grant; rst has priority over flush.

Reset
REQ-028 While rst high: all counts, head/tail pointers, rr_ptr=0; wb_valid=0, wb_Pd=0, wb_RegWr=0, wb_tag_rob=0, wb_data=0, wb_src=0, overflow=0, stall_out all 0.
REQ-029 rst asserted mid-operation SHALL discard all buffered entries immediately, without waiting for a clock edge.
REQ-030 First push SHALL be accepted at the first rising edge after rst deasserts.

Verification
REQ-031 Single source: valid_in[1]=1, Pd=5, tag=9, data=0x1234 at edge 0 -> stall_out[1]=1 after edge 0; wb_valid=1, wb_src=1, wb_Pd=5, wb_data=0x1234 after edge 1; stall_out[1]=0 after edge 1.
REQ-032 Round-robin: all three FIFOs loaded with one entry each, rr_ptr=0 -> wb_src sequence 0,1,2 on three consecutive cycles, then wb_valid=0.
REQ-033 Fairness: source 0 pushes every possible cycle, source 2 holds one entry -> source 2 granted within 2 cycles; no source waits more than NSRC grants.
REQ-034 Overflow: source 0 ignores stall, pushes 3 entries on consecutive edges while source 1 holds grant priority -> third entry dropped, overflow=1, remaining two drained in order.
REQ-035 Flush: two sources holding entries, flush=1 with valid_in[0]=1 -> after edge all counts 0, wb_valid=0, stall_out=0; no stale entry ever appears on wb_*.
REQ-036 Async reset: assert rst between edges with FIFOs non-empty -> wb_valid and stall_out drop to 0 before next edge; overflow=0.
